// File: rtl/aes_cmd_sequencer_if.sv
// Descriptor, aes_top byte bus and response signals of the command sequencer.
// master: the sequencer side (drives the byte bus, accepts descriptors).
// slave: the environment side (descriptor source plus aes_top).
interface aes_cmd_sequencer_if;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [15:0]  cmd_addr;
  logic [15:0]  cmd_len;
  logic [127:0] cmd_key;
  logic [127:0] cmd_ctr;
  logic         cmd_keyld;
  logic         bus_stb;
  logic         bus_wr;
  logic [15:0]  bus_addr;
  logic [7:0]   bus_wdata;
  logic         bus_ack;
  logic [7:0]   bus_rdata;
  logic         busy;
  logic         resp_valid;
  logic [1:0]   resp_code;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, cmd_key, cmd_ctr, cmd_keyld,
    input  bus_ack, bus_rdata,
    output cmd_ready, bus_stb, bus_wr, bus_addr, bus_wdata,
    output busy, resp_valid, resp_code
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, cmd_key, cmd_ctr, cmd_keyld,
    output bus_ack, bus_rdata,
    input  cmd_ready, bus_stb, bus_wr, bus_addr, bus_wdata,
    input  busy, resp_valid, resp_code
  );
endinterface

// File: rtl/aes_cmd_sequencer.sv
// Programs the aes_top register bus from one descriptor, starts the core,
// polls its state register until idle and reports a one-cycle response.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | cmd_ready high, waiting for a descriptor
// S_CHK     | length check, no bus activity
// S_WR_ADDR | writing XRAM address bytes to ff02/ff03
// S_WR_LEN  | writing length bytes to ff04/ff05
// S_WR_KEY  | writing key bytes to ff10..ff1f (only when keyld)
// S_WR_CTR  | writing counter bytes to ff20..ff2f
// S_START   | writing 01 to ff00
// S_GAP     | bus idle for POLL_GAP cycles before the next state read
// S_POLL    | reading ff01
// S_DONE    | resp_valid pulse, resp_code updated
module aes_cmd_sequencer #(
  parameter int MAX_OPLEN = 16,
  parameter int POLL_GAP  = 4,
  parameter int TIMEOUT   = 1024
) (
  input logic                clk,
  input logic                rst,
  aes_cmd_sequencer_if.master io
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  localparam logic [1:0] CODE_OK      = 2'b00;
  localparam logic [1:0] CODE_BADLEN  = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_CHK, S_WR_ADDR, S_WR_LEN, S_WR_KEY, S_WR_CTR,
    S_START, S_GAP, S_POLL, S_DONE
  } state_t;

  state_t         state;
  logic [3:0]     idx;
  logic [GW-1:0]  gap_cnt;
  logic [TW-1:0]  tmo;
  logic [15:0]    addr_q;
  logic [15:0]    len_q;
  logic [127:0]   key_q;
  logic [127:0]   ctr_q;
  logic           keyld_q;

  logic           cmd_ready;
  logic           stb;
  logic           wr;
  logic [15:0]    baddr;
  logic [7:0]     wdata;
  logic           busy;
  logic           resp_valid;
  logic [1:0]     resp_code;

  logic           xfer_done;
  logic           tmo_hit;
  logic           len_bad;
  logic           poll_idle;
  state_t         adv_state;
  logic [3:0]     adv_idx;
  logic [15:0]    nxt_addr;
  logic [7:0]     nxt_data;

  assign xfer_done = stb && io.bus_ack;
  assign tmo_hit   = (tmo == TW'(TIMEOUT));
  assign len_bad   = (len_q == 16'd0) || (len_q > 16'(MAX_OPLEN));
  assign poll_idle = (io.bus_rdata[1:0] == 2'b00);

  // Which write follows the current one, and the address/data it carries.
  // CHK maps onto the first address byte so the write path is entered uniformly.
  always_comb begin
    adv_state = state;
    adv_idx   = idx + 4'd1;
    case (state)
      S_CHK: begin
        adv_state = S_WR_ADDR;
        adv_idx   = 4'd0;
      end
      S_WR_ADDR: if (idx == 4'd1) begin
        adv_state = S_WR_LEN;
        adv_idx   = 4'd0;
      end
      S_WR_LEN: if (idx == 4'd1) begin
        adv_state = keyld_q ? S_WR_KEY : S_WR_CTR;
        adv_idx   = 4'd0;
      end
      S_WR_KEY: if (idx == 4'd15) begin
        adv_state = S_WR_CTR;
        adv_idx   = 4'd0;
      end
      S_WR_CTR: if (idx == 4'd15) begin
        adv_state = S_START;
        adv_idx   = 4'd0;
      end
      default: ;
    endcase

    nxt_addr = 16'h0000;
    nxt_data = 8'h00;
    case (adv_state)
      S_WR_ADDR: begin
        nxt_addr = {15'h7f81, adv_idx[0]};
        nxt_data = adv_idx[0] ? addr_q[15:8] : addr_q[7:0];
      end
      S_WR_LEN: begin
        nxt_addr = {15'h7f82, adv_idx[0]};
        nxt_data = adv_idx[0] ? len_q[15:8] : len_q[7:0];
      end
      S_WR_KEY: begin
        nxt_addr = {12'hff1, adv_idx};
        nxt_data = key_q[{adv_idx, 3'b000} +: 8];
      end
      S_WR_CTR: begin
        nxt_addr = {12'hff2, adv_idx};
        nxt_data = ctr_q[{adv_idx, 3'b000} +: 8];
      end
      S_START: begin
        nxt_addr = 16'hff00;
        nxt_data = 8'h01;
      end
      default: ;
    endcase
  end

  // Sequencer FSM with registered bus and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= 4'd0;
      gap_cnt    <= '0;
      tmo        <= '0;
      addr_q     <= 16'd0;
      len_q      <= 16'd0;
      key_q      <= 128'd0;
      ctr_q      <= 128'd0;
      keyld_q    <= 1'b0;
      cmd_ready  <= 1'b1;
      stb        <= 1'b0;
      wr         <= 1'b0;
      baddr      <= 16'd0;
      wdata      <= 8'd0;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_code  <= CODE_OK;
    end else begin
      resp_valid <= 1'b0;
      // the timeout count only runs while waiting for the core, and saturates
      if ((state == S_GAP || state == S_POLL) && !tmo_hit)
        tmo <= tmo + TW'(1);

      case (state)
        S_IDLE: begin
          if (io.cmd_valid && cmd_ready) begin
            addr_q    <= io.cmd_addr;
            len_q     <= io.cmd_len;
            key_q     <= io.cmd_key;
            ctr_q     <= io.cmd_ctr;
            keyld_q   <= io.cmd_keyld;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= S_CHK;
          end
        end

        S_CHK: begin
          if (len_bad) begin
            state      <= S_DONE;
            resp_valid <= 1'b1;
            resp_code  <= CODE_BADLEN;
          end else begin
            state <= adv_state;
            idx   <= adv_idx;
            stb   <= 1'b1;
            wr    <= 1'b1;
            baddr <= nxt_addr;
            wdata <= nxt_data;
          end
        end

        S_WR_ADDR, S_WR_LEN, S_WR_KEY, S_WR_CTR: begin
          // back-to-back: stb stays high, the next byte is presented at once
          if (xfer_done) begin
            state <= adv_state;
            idx   <= adv_idx;
            baddr <= nxt_addr;
            wdata <= nxt_data;
          end
        end

        S_START: begin
          if (xfer_done) begin
            stb     <= 1'b0;
            wr      <= 1'b0;
            baddr   <= 16'd0;
            wdata   <= 8'd0;
            idx     <= 4'd0;
            tmo     <= '0;
            gap_cnt <= GW'(POLL_GAP - 1);
            state   <= S_GAP;
          end
        end

        S_GAP: begin
          if (tmo_hit) begin
            state      <= S_DONE;
            resp_valid <= 1'b1;
            resp_code  <= CODE_TIMEOUT;
          end else if (gap_cnt == '0) begin
            state <= S_POLL;
            stb   <= 1'b1;
            wr    <= 1'b0;
            baddr <= 16'hff01;
            wdata <= 8'd0;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end

        S_POLL: begin
          // a read in flight always finishes its handshake before timing out
          if (xfer_done) begin
            stb   <= 1'b0;
            baddr <= 16'd0;
            if (poll_idle) begin
              state      <= S_DONE;
              resp_valid <= 1'b1;
              resp_code  <= CODE_OK;
            end else if (tmo_hit) begin
              state      <= S_DONE;
              resp_valid <= 1'b1;
              resp_code  <= CODE_TIMEOUT;
            end else begin
              gap_cnt <= GW'(POLL_GAP - 1);
              state   <= S_GAP;
            end
          end
        end

        S_DONE: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign io.cmd_ready  = cmd_ready;
  assign io.bus_stb    = stb;
  assign io.bus_wr     = wr;
  assign io.bus_addr   = baddr;
  assign io.bus_wdata  = wdata;
  assign io.busy       = busy;
  assign io.resp_valid = resp_valid;
  assign io.resp_code  = resp_code;

endmodule
